sem_channel: RTL and testbench

- Inter-core semaphore/mailbox channel. Sits between a producer controller's sem_data_out/sem_data_valid_out/sem_data_empty ports and a consumer controller's sem_data_in/sem_data_valid_in/sem_data_read ports.
- Buffers up to DEPTH data words in a first-word-fall-through FIFO.
- Exposes empty/full status and the fill level.
- Sets sticky error flags on overflow and underflow attempts.

---
 rtl/sem_channel.sv | 81 ++++++++
 tb/tb_sem_channel.sv | 128 ++++++++++++
 2 files changed

// File: rtl/sem_channel.sv
// sem_channel: inter-core semaphore/mailbox channel.
// A first-word-fall-through FIFO between a producer and a consumer controller.
// It reports empty/full status and the fill level, and it keeps sticky error flags
// for writes attempted while full and reads attempted while empty.
module sem_channel #(
  parameter int DATA_WIDTH = 1,
  parameter int DEPTH      = 4,
  parameter int PTR_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  empty,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_read,
  output logic [PTR_WIDTH:0]    level,
  output logic                  ovf_err,
  output logic                  udf_err
);

  localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] ONE_COUNT  = (PTR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [PTR_WIDTH:0]    count;
  logic                  push;
  logic                  pop;

  // Status comes only from the registered occupancy count. Full and empty are
  // evaluated on the state before the edge, so nothing bypasses within a cycle.
  assign empty    = (count == '0);
  assign full     = (count == FULL_COUNT);
  assign rd_valid = !empty;
  assign level    = count;
  assign rd_data  = empty ? '0 : mem[rd_ptr];

  assign push = wr_valid && !full;
  assign pop  = rd_read && rd_valid;

  // Storage write port. Contents are don't-care after reset, so this block has no reset branch.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy and sticky error flags. Reset overrides any traffic in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + ONE_COUNT;
        2'b01:   count <= count - ONE_COUNT;
        default: count <= count;
      endcase
      if (wr_valid && full) begin
        ovf_err <= 1'b1;
      end
      if (rd_read && empty) begin
        udf_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sem_channel.sv
// Testbench for sem_channel.
// A queue-based reference model is checked against the design after every clock edge.
// Directed sequences run first, followed by randomized traffic with occasional resets.
module tb_sem_channel;

  localparam int DW    = 1;
  localparam int DEPTH = 4;
  localparam int PW    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          rd_read = 1'b0;
  logic          empty, full, rd_valid, ovf_err, udf_err;
  logic [DW-1:0] rd_data;
  logic [PW:0]   level;

  int n_compared = 0;
  int n_mismatched = 0;
  int n_cycles = 0;

  // Reference model state
  logic [DW-1:0] model_q[$];
  bit            model_ovf = 1'b0;
  bit            model_udf = 1'b0;

  sem_channel #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid),
    .empty(empty), .full(full), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_read(rd_read), .level(level), .ovf_err(ovf_err), .udf_err(udf_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_compared++;
    if (obs != exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, n_cycles);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare at the negedge.
  task automatic cycle(input bit wv, input bit [DW-1:0] wd, input bit rr, input bit rs);
    bit was_full, was_empty;
    int exp_data;
    wr_valid = wv;
    wr_data  = wd;
    rd_read  = rr;
    rst      = rs;
    @(posedge clk);
    if (rs) begin
      model_q.delete();
      model_ovf = 1'b0;
      model_udf = 1'b0;
    end else begin
      was_full  = (model_q.size() == DEPTH);
      was_empty = (model_q.size() == 0);
      if (wv && was_full) model_ovf = 1'b1;
      if (rr && was_empty) model_udf = 1'b1;
      if (rr && !was_empty) void'(model_q.pop_front());
      if (wv && !was_full) model_q.push_back(wd);
    end
    @(negedge clk);
    n_cycles++;
    exp_data = (model_q.size() != 0) ? int'(model_q[0]) : 0;
    check_eq("empty",    int'(empty),    int'(model_q.size() == 0));
    check_eq("full",     int'(full),     int'(model_q.size() == DEPTH));
    check_eq("rd_valid", int'(rd_valid), int'(model_q.size() != 0));
    check_eq("level",    int'(level),    model_q.size());
    check_eq("rd_data",  int'(rd_data),  exp_data);
    check_eq("ovf_err",  int'(ovf_err),  int'(model_ovf));
    check_eq("udf_err",  int'(udf_err),  int'(model_udf));
    $display("cyc %0d rst=%0b wv=%0b wd=%0d rr=%0b -> level=%0d rd_data=%0d ovf=%0b udf=%0b",
             n_cycles, rs, wv, wd, rr, level, rd_data, ovf_err, udf_err);
  endtask

  initial begin
    bit [DW-1:0] pat [4];
    int wr_pct, rd_pct;
    pat[0] = 1; pat[1] = 0; pat[2] = 1; pat[3] = 1;

    // Reset, then idle
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);

    // Fill with 1,0,1,1, then drain
    for (int i = 0; i < 4; i++) cycle(1, pat[i], 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);

    // Overflow attempt while full; the dropped 0 must never appear
    for (int i = 0; i < 4; i++) cycle(1, pat[i], 0, 0);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);
    check_eq("drained_after_ovf", int'(empty), 1);

    // Simultaneous write and read while empty: write taken, read flagged
    cycle(1, 1, 1, 0);
    check_eq("bypass_level", int'(level), 1);
    cycle(0, 0, 1, 0);

    // Steady state at level 2 with simultaneous push and pop; pointers wrap
    cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 0);
    for (int i = 0; i < 6; i++) cycle(1, DW'(i & 1), 1, 0);

    // Level 3, then reset together with a write
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 1);
    check_eq("rst_discard_level", int'(level), 0);

    // Randomized traffic, phases biased toward filling or draining
    for (int i = 0; i < 3000; i++) begin
      case ((i / 150) % 3)
        0:       begin wr_pct = 80; rd_pct = 25; end
        1:       begin wr_pct = 25; rd_pct = 80; end
        default: begin wr_pct = 50; rd_pct = 50; end
      endcase
      cycle(($urandom_range(99) < wr_pct), DW'($urandom), ($urandom_range(99) < rd_pct),
            ($urandom_range(199) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
